mont_modexp_ctrl: RTL and testbench

Sequencing controller that computes base^exp mod m by driving an external `montgomery_mult` instance through its enable/done interface. It is the initiator side of the multiplier protocol and performs left-to-right square-and-multiply in the Montgomery domain. It sits between the RSA top level, which supplies operands and R² mod m, and the multiplier datapath.

---
 rtl/rsa_pkg.sv | 22 ++
 rtl/mont_modexp_ctrl_if.sv | 27 ++
 rtl/mont_modexp_ctrl.sv | 138 +++++++++++++
 tb/tb_mont_modexp_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types for the RSA modular-exponentiation path: controller state and
// Montgomery operation encodings plus the default operand width.
package rsa_pkg;

    localparam int DEFAULT_WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINISH
    } modexp_state_t;

    typedef enum logic [2:0] {
        TO_MONT_B,
        TO_MONT_1,
        SQUARE,
        MUL,
        FROM_MONT
    } modexp_op_t;

endpackage

// File: rtl/mont_modexp_ctrl_if.sv
// Request/response bus between the modexp controller (master) and a
// montgomery_mult instance (slave).
interface mont_modexp_ctrl_if
    import rsa_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
);

    logic                  mm_enable;
    logic [WORD_WIDTH-1:0] mm_x;
    logic [WORD_WIDTH-1:0] mm_y;
    logic [WORD_WIDTH-1:0] mm_m;
    logic [WORD_WIDTH:0]   mm_R;
    logic                  mm_done;
    logic [WORD_WIDTH-1:0] mm_result;

    modport master (
        output mm_enable, mm_x, mm_y, mm_m, mm_R,
        input  mm_done, mm_result
    );

    modport slave (
        input  mm_enable, mm_x, mm_y, mm_m, mm_R,
        output mm_done, mm_result
    );

endinterface

// File: rtl/mont_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing base^exp mod m in the
// Montgomery domain by issuing one request at a time to an external multiplier.
module mont_modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int EXP_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [WORD_WIDTH-1:0] m,
    input  logic [WORD_WIDTH-1:0] base,
    input  logic [EXP_WIDTH-1:0]  exp,
    input  logic [WORD_WIDTH-1:0] r2_mod_m,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] result,
    mont_modexp_ctrl_if.master    mm
);

    localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    modexp_state_t         state, state_nx;
    modexp_op_t            op, op_nx;
    logic [WORD_WIDTH-1:0] m_r, base_r, r2_r, xbar, acc, result_q;
    logic [EXP_WIDTH-1:0]  exp_r;
    logic [IDX_W-1:0]      bit_idx;
    logic                  done_q;
    logic                  bit_done, last_bit;

    // A bit is finished after its SQUARE when the bit is 0, or after its MUL.
    assign bit_done = ((op == SQUARE) && !exp_r[bit_idx]) || (op == MUL);
    assign last_bit = (bit_idx == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            op    <= TO_MONT_B;
        end else begin
            state <= state_nx;
            op    <= op_nx;
        end
    end

    always_comb begin
        state_nx = state;
        op_nx    = op;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nx = ISSUE;
                    op_nx    = TO_MONT_B;
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (mm.mm_done) begin
                    state_nx = ISSUE;
                    case (op)
                        TO_MONT_B: op_nx = TO_MONT_1;
                        TO_MONT_1: op_nx = SQUARE;
                        SQUARE:    op_nx = exp_r[bit_idx] ? MUL : (last_bit ? FROM_MONT : SQUARE);
                        MUL:       op_nx = last_bit ? FROM_MONT : SQUARE;
                        default:   state_nx = FINISH;
                    endcase
                end
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operands come straight from held registers, so they stay stable in WAIT.
    always_comb begin
        mm.mm_enable = (state == ISSUE);
        mm.mm_m      = m_r;
        mm.mm_R      = {1'b1, {WORD_WIDTH{1'b0}}};
        mm.mm_x      = acc;
        mm.mm_y      = acc;
        case (op)
            TO_MONT_B: begin
                mm.mm_x = base_r;
                mm.mm_y = r2_r;
            end
            TO_MONT_1: begin
                mm.mm_x = WORD_WIDTH'(1);
                mm.mm_y = r2_r;
            end
            MUL:       mm.mm_y = xbar;
            FROM_MONT: mm.mm_y = WORD_WIDTH'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_r      <= '0;
            base_r   <= '0;
            r2_r     <= '0;
            exp_r    <= '0;
            xbar     <= '0;
            acc      <= '0;
            result_q <= '0;
            bit_idx  <= '0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        m_r     <= m;
                        base_r  <= base;
                        r2_r    <= r2_mod_m;
                        exp_r   <= exp;
                        bit_idx <= IDX_W'(EXP_WIDTH - 1);
                        done_q  <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mm.mm_done) begin
                        case (op)
                            TO_MONT_B: xbar     <= mm.mm_result;
                            FROM_MONT: result_q <= mm.mm_result;
                            default:   acc      <= mm.mm_result;
                        endcase
                        if (bit_done && !last_bit)
                            bit_idx <= bit_idx - IDX_W'(1);
                    end
                end
                FINISH:  done_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Bench for mont_modexp_ctrl: behavioural Montgomery multiplier with random
// latency, directed cases and randomized runs checked against plain modexp.
module tb_mont_modexp_ctrl;

    localparam int WW = 32;
    localparam int EW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [WW-1:0] m = '0, base = '0, r2 = '0;
    logic [EW-1:0] exp_i = '0;
    logic          done;
    logic [WW-1:0] result;

    mont_modexp_ctrl_if #(.WORD_WIDTH(WW)) mmif ();

    mont_modexp_ctrl #(.WORD_WIDTH(WW), .EXP_WIDTH(EW)) dut (
        .clk      (clk),
        .reset    (rst),
        .enable   (enable),
        .m        (m),
        .base     (base),
        .exp      (exp_i),
        .r2_mod_m (r2),
        .done     (done),
        .result   (result),
        .mm       (mmif)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [WW-1:0] mont_mul(input logic [WW-1:0] x, y, mm);
        logic [127:0] t;
        t = 128'(x) * 128'(y);
        for (int i = 0; i < WW; i++) begin
            if (t[0]) t = t + 128'(mm);
            t = t >> 1;
        end
        return (mm == '0) ? '0 : WW'(t % 128'(mm));
    endfunction

    function automatic logic [WW-1:0] r2of(input logic [WW-1:0] mm);
        logic [127:0] one64;
        one64 = 128'd1 << (2 * WW);
        return (mm == '0) ? '0 : WW'(one64 % 128'(mm));
    endfunction

    // Golden: right-to-left binary exponentiation with ordinary modular products.
    function automatic logic [WW-1:0] golden(input logic [WW-1:0] b, input logic [EW-1:0] e,
                                             input logic [WW-1:0] mm);
        logic [63:0] r, p;
        r = 64'(1) % 64'(mm);
        p = 64'(b) % 64'(mm);
        for (int i = 0; i < EW; i++) begin
            if (e[i]) r = (r * p) % 64'(mm);
            p = (p * p) % 64'(mm);
        end
        return WW'(r);
    endfunction

    // Multiplier model: clears done on request, raises it after lat WAIT cycles.
    logic mdl_done;
    logic stray_en = 1'b0;
    int   cnt;
    assign mmif.mm_done = mdl_done | (stray_en & mmif.mm_enable);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_done       <= 1'b0;
            cnt            <= 0;
            mmif.mm_result <= '0;
        end else if (mmif.mm_enable) begin
            mdl_done       <= 1'b0;
            cnt            <= int'($urandom_range(2, 3)) - 1;
            mmif.mm_result <= mont_mul(mmif.mm_x, mmif.mm_y, mmif.mm_m);
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) mdl_done <= 1'b1;
        end
    end

    // Monitor: request count, back-to-back requests, operand stability in WAIT.
    int            pulses = 0, consec_cnt = 0, unstable_cnt = 0;
    logic          waiting = 1'b0, prev_en = 1'b0;
    logic [WW-1:0] cap_x, cap_y;

    always @(negedge clk) begin
        if (rst) begin
            waiting = 1'b0;
            prev_en = 1'b0;
        end else begin
            if (mmif.mm_enable) begin
                pulses++;
                if (prev_en) consec_cnt++;
                cap_x   = mmif.mm_x;
                cap_y   = mmif.mm_y;
                waiting = 1'b1;
            end else if (waiting) begin
                if (mmif.mm_x !== cap_x || mmif.mm_y !== cap_y) unstable_cnt++;
                if (mmif.mm_done) waiting = 1'b0;
            end
            prev_en = mmif.mm_enable;
        end
    end

    int p0, u0, c0;

    task automatic start_run(input logic [WW-1:0] b, input logic [EW-1:0] e, input logic [WW-1:0] mm);
        @(negedge clk);
        #1;
        p0     = pulses;
        u0     = unstable_cnt;
        c0     = consec_cnt;
        base   = b;
        exp_i  = e;
        m      = mm;
        r2     = r2of(mm);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_pulses(input int n);
        int k;
        k = 0;
        while ((pulses - p0) < n && k < 500) begin
            @(negedge clk);
            #1;
            k++;
        end
        if ((pulses - p0) < n) check_eq("pulse_timeout", 64'(pulses - p0), 64'(n));
    endtask

    task automatic finish_run(input string tag, input logic [WW-1:0] b, input logic [EW-1:0] e,
                              input logic [WW-1:0] mm);
        int k;
        k = 0;
        while (!done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!done) check_eq({tag, "_timeout"}, 64'(done), 64'(1));
        #1;
        check_eq({tag, "_result"}, 64'(result), 64'(golden(b, e, mm)));
        check_eq({tag, "_count"}, 64'(pulses - p0), 64'(3 + EW + $countones(e)));
        check_eq({tag, "_stable"}, 64'(unstable_cnt - u0), 64'(0));
        check_eq({tag, "_consec"}, 64'(consec_cnt - c0), 64'(0));
    endtask

    initial begin
        logic [WW-1:0] rm, rb;
        logic [EW-1:0] re;

        repeat (3) @(negedge clk);
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_result", 64'(result), 64'(0));
        check_eq("rst_mm_enable", 64'(mmif.mm_enable), 64'(0));
        check_eq("rst_mm_x", 64'(mmif.mm_x), 64'(0));
        rst = 1'b0;

        // Basic: 4^13 mod 497 = 445, 38 requests, first request right after start.
        start_run(32'd4, 32'd13, 32'd497);
        check_eq("first_req", 64'(mmif.mm_enable), 64'(1));
        check_eq("mm_R", 64'(mmif.mm_R), 64'h1_0000_0000);
        check_eq("mm_m", 64'(mmif.mm_m), 64'd497);
        finish_run("basic", 32'd4, 32'd13, 32'd497);
        check_eq("basic_445", 64'(result), 64'd445);

        start_run(32'd2, 32'd10, 32'd1009);
        finish_run("red2", 32'd2, 32'd10, 32'd1009);
        check_eq("red2_15", 64'(result), 64'd15);
        start_run(32'd3, 32'd1, 32'd7);
        check_eq("done_drop", 64'(done), 64'(0));
        finish_run("red3", 32'd3, 32'd1, 32'd7);
        check_eq("red3_3", 64'(result), 64'd3);

        start_run(32'd5, 32'd0, 32'd7);
        finish_run("exp0", 32'd5, 32'd0, 32'd7);
        check_eq("exp0_1", 64'(result), 64'd1);
        start_run(32'd0, 32'd5, 32'd1);
        finish_run("m1", 32'd0, 32'd5, 32'd1);
        check_eq("m1_0", 64'(result), 64'd0);

        // Busy: new operands + enable during WAIT, stray done during every ISSUE.
        stray_en = 1'b1;
        start_run(32'd4, 32'd13, 32'd497);
        wait_pulses(5);
        @(negedge clk);
        base = 32'd9; exp_i = 32'd3; m = 32'd11; r2 = r2of(32'd11);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        finish_run("busy", 32'd4, 32'd13, 32'd497);
        check_eq("busy_445", 64'(result), 64'd445);
        stray_en = 1'b0;

        // Reset while waiting on the first SQUARE.
        start_run(32'd4, 32'd13, 32'd497);
        wait_pulses(3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("mrst_done", 64'(done), 64'(0));
        check_eq("mrst_result", 64'(result), 64'(0));
        check_eq("mrst_mm_enable", 64'(mmif.mm_enable), 64'(0));
        check_eq("mrst_mm_xy", 64'({mmif.mm_x, mmif.mm_y}), 64'(0));
        check_eq("mrst_mm_m", 64'(mmif.mm_m), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("mrst_no_stale", 64'({done, result}), 64'(0));
        start_run(32'd4, 32'd13, 32'd497);
        finish_run("post_rst", 32'd4, 32'd13, 32'd497);

        for (int i = 0; i < 200; i++) begin
            rm = $urandom | 32'd1;
            rb = $urandom % rm;
            re = $urandom;
            start_run(rb, re, rm);
            finish_run("rand", rb, re, rm);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
